// File: rtl/rv_timer_sched_pkg.sv
// Shared types and constants for the timer deadline scheduler.
// FSM states, slot record layout and the "no deadline armed" compare value.
package rv_timer_sched_pkg;

  localparam int SlotTimerW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIRE = 2'd2
  } state_e;

  typedef struct packed {
    logic                  armed;
    logic [SlotTimerW-1:0] deadline;
  } slot_t;

  // All-ones compare value keeps the timer from ever matching while nothing is armed.
  localparam logic [SlotTimerW-1:0] TimerDisabled = '1;

endpackage

// File: rtl/rv_timer_sched_slots.sv
// Deadline slot register file: one write port (arm/cancel/expire-clear),
// one read port addressed by the scan index, and the raw armed vector.
module rv_timer_sched_slots #(
  parameter int NumSlots = 4,
  parameter int TimerW   = 64,
  parameter int IdW      = $clog2(NumSlots)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [IdW-1:0]      wr_id_i,
  input  logic                wr_arm_i,
  input  logic [TimerW-1:0]   wr_deadline_i,
  input  logic [IdW-1:0]      rd_idx_i,
  output logic                rd_armed_o,
  output logic [TimerW-1:0]   rd_deadline_o,
  output logic [NumSlots-1:0] armed_o
);

  logic [NumSlots-1:0] armed_q;
  logic [TimerW-1:0]   deadline_q [NumSlots];

  // Ids at or above NumSlots match no slot, so such writes fall through harmlessly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        deadline_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      for (int i = 0; i < NumSlots; i++) begin
        if (wr_id_i == IdW'(i)) begin
          armed_q[i] <= wr_arm_i;
          if (wr_arm_i) begin
            deadline_q[i] <= wr_deadline_i;
          end
        end
      end
    end
  end

  assign rd_armed_o    = armed_q[rd_idx_i];
  assign rd_deadline_o = deadline_q[rd_idx_i];
  assign armed_o       = armed_q;

endmodule

// File: rtl/rv_timer_sched.sv
// Multiplexes one 64-bit timer compare channel between NumSlots deadlines,
// rescanning for the earliest armed slot after every change and reporting expiries.
module rv_timer_sched
  import rv_timer_sched_pkg::*;
#(
  parameter  int NumSlots = 4,
  parameter  int TimerW   = 64,
  localparam int IdW      = $clog2(NumSlots)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                arm_valid_i,
  output logic                arm_ready_o,
  input  logic [IdW-1:0]      arm_id_i,
  input  logic                arm_cancel_i,
  input  logic [TimerW-1:0]   arm_deadline_i,
  input  logic [TimerW-1:0]   mtime_i,
  output logic [TimerW-1:0]   cmp_value_o,
  output logic                cmp_valid_o,
  output logic                cmp_update_o,
  output logic                expired_valid_o,
  output logic [IdW-1:0]      expired_id_o,
  input  logic                expired_ready_i,
  output logic [NumSlots-1:0] armed_o
);

  state_e            state_q, state_d;
  logic [IdW-1:0]    scanIdx_q, scanIdx_d;
  logic [TimerW-1:0] minDeadline_q, minDeadline_d;
  logic [IdW-1:0]    minId_q, minId_d;
  logic              minFound_q, minFound_d;
  logic [TimerW-1:0] cmpValue_q, cmpValue_d;
  logic              cmpValid_q, cmpValid_d;
  logic              cmpUpdate_q, cmpUpdate_d;
  logic [IdW-1:0]    fireId_q, fireId_d;

  logic              wrEn, wrArm;
  logic [IdW-1:0]    wrId;
  logic              rdArmed;
  logic [TimerW-1:0] rdDeadline;
  logic              hit, prevFound, take, armReady, expValid;

  rv_timer_sched_slots #(
    .NumSlots(NumSlots),
    .TimerW  (TimerW),
    .IdW     (IdW)
  ) u_slots (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .wr_en_i      (wrEn),
    .wr_id_i      (wrId),
    .wr_arm_i     (wrArm),
    .wr_deadline_i(arm_deadline_i),
    .rd_idx_i     (scanIdx_q),
    .rd_armed_o   (rdArmed),
    .rd_deadline_o(rdDeadline),
    .armed_o      (armed_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      scanIdx_q     <= '0;
      minDeadline_q <= '0;
      minId_q       <= '0;
      minFound_q    <= 1'b0;
      cmpValue_q    <= TimerW'(TimerDisabled);
      cmpValid_q    <= 1'b0;
      cmpUpdate_q   <= 1'b0;
      fireId_q      <= '0;
    end else begin
      state_q       <= state_d;
      scanIdx_q     <= scanIdx_d;
      minDeadline_q <= minDeadline_d;
      minId_q       <= minId_d;
      minFound_q    <= minFound_d;
      cmpValue_q    <= cmpValue_d;
      cmpValid_q    <= cmpValid_d;
      cmpUpdate_q   <= cmpUpdate_d;
      fireId_q      <= fireId_d;
    end
  end

  // The running minimum restarts at index 0; strict less-than keeps the lowest id on ties.
  always_comb begin
    state_d       = state_q;
    scanIdx_d     = scanIdx_q;
    minDeadline_d = minDeadline_q;
    minId_d       = minId_q;
    minFound_d    = minFound_q;
    cmpValue_d    = cmpValue_q;
    cmpValid_d    = cmpValid_q;
    cmpUpdate_d   = 1'b0;
    fireId_d      = fireId_q;
    wrEn          = 1'b0;
    wrId          = arm_id_i;
    wrArm         = !arm_cancel_i;
    armReady      = 1'b0;
    expValid      = 1'b0;

    hit       = cmpValid_q && (mtime_i >= cmpValue_q);
    prevFound = (scanIdx_q == '0) ? 1'b0 : minFound_q;
    take      = rdArmed && (!prevFound || (rdDeadline < minDeadline_q));

    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = FIRE;
        end else begin
          armReady = 1'b1;
          if (arm_valid_i) begin
            wrEn      = 1'b1;
            state_d   = SCAN;
            scanIdx_d = '0;
          end
        end
      end
      SCAN: begin
        minFound_d = prevFound || take;
        if (take) begin
          minDeadline_d = rdDeadline;
          minId_d       = scanIdx_q;
        end
        if (scanIdx_q == IdW'(NumSlots - 1)) begin
          state_d     = IDLE;
          cmpUpdate_d = 1'b1;
          cmpValid_d  = prevFound || take;
          if (take) begin
            cmpValue_d = rdDeadline;
            fireId_d   = scanIdx_q;
          end else if (prevFound) begin
            cmpValue_d = minDeadline_q;
            fireId_d   = minId_q;
          end else begin
            cmpValue_d = TimerW'(TimerDisabled);
            fireId_d   = '0;
          end
        end else begin
          scanIdx_d = scanIdx_q + 1'b1;
        end
      end
      FIRE: begin
        expValid = 1'b1;
        if (expired_ready_i) begin
          wrEn      = 1'b1;
          wrId      = fireId_q;
          wrArm     = 1'b0;
          state_d   = SCAN;
          scanIdx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arm_ready_o     = armReady && !rst_i;
  assign cmp_value_o     = cmpValue_q;
  assign cmp_valid_o     = cmpValid_q;
  assign cmp_update_o    = cmpUpdate_q;
  assign expired_valid_o = expValid;
  assign expired_id_o    = expValid ? fireId_q : '0;

endmodule

// File: tb/tb_rv_timer_sched.sv
// Directed plus randomized bench for rv_timer_sched against a slot-table
// reference model (earliest deadline, lowest id on ties).
module tb_rv_timer_sched;

  localparam int NumSlots = 4;
  localparam int TimerW   = 64;
  localparam int IdW      = 2;
  localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                arm_valid_i;
  logic                arm_ready_o;
  logic [IdW-1:0]      arm_id_i;
  logic                arm_cancel_i;
  logic [TimerW-1:0]   arm_deadline_i;
  logic [TimerW-1:0]   mtime_i;
  logic [TimerW-1:0]   cmp_value_o;
  logic                cmp_valid_o;
  logic                cmp_update_o;
  logic                expired_valid_o;
  logic [IdW-1:0]      expired_id_o;
  logic                expired_ready_i;
  logic [NumSlots-1:0] armed_o;

  int compared   = 0;
  int mismatched = 0;

  logic        modelArmed [NumSlots];
  logic [63:0] modelDl    [NumSlots];

  always #5 clk_i = ~clk_i;

  rv_timer_sched #(
    .NumSlots(NumSlots),
    .TimerW  (TimerW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .arm_valid_i    (arm_valid_i),
    .arm_ready_o    (arm_ready_o),
    .arm_id_i       (arm_id_i),
    .arm_cancel_i   (arm_cancel_i),
    .arm_deadline_i (arm_deadline_i),
    .mtime_i        (mtime_i),
    .cmp_value_o    (cmp_value_o),
    .cmp_valid_o    (cmp_valid_o),
    .cmp_update_o   (cmp_update_o),
    .expired_valid_o(expired_valid_o),
    .expired_id_o   (expired_id_o),
    .expired_ready_i(expired_ready_i),
    .armed_o        (armed_o)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < NumSlots; i++) begin
      modelArmed[i] = 1'b0;
      modelDl[i]    = '0;
    end
  endtask

  function automatic logic modelAny();
    logic any = 1'b0;
    for (int i = 0; i < NumSlots; i++) any |= modelArmed[i];
    return any;
  endfunction

  function automatic logic [63:0] modelMin();
    logic [63:0] m = AllOnes;
    for (int i = 0; i < NumSlots; i++)
      if (modelArmed[i] && modelDl[i] < m) m = modelDl[i];
    return m;
  endfunction

  function automatic int modelNextId();
    logic [63:0] m = modelMin();
    for (int i = 0; i < NumSlots; i++)
      if (modelArmed[i] && modelDl[i] == m) return i;
    return -1;
  endfunction

  function automatic logic [63:0] modelArmedVec();
    logic [63:0] v = '0;
    for (int i = 0; i < NumSlots; i++) v[i] = modelArmed[i];
    return v;
  endfunction

  task automatic waitScanDone(input string tag);
    int lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      if (cmp_update_o) begin
        lat = k;
        break;
      end
    end
    checkOutput({tag, "_updLatency"}, 64'(lat), 64'd5);
    checkOutput({tag, "_cmpValid"}, 64'(cmp_valid_o), 64'(modelAny()));
    checkOutput({tag, "_cmpValue"}, cmp_value_o, modelAny() ? modelMin() : AllOnes);
    checkOutput({tag, "_armed"}, 64'(armed_o), modelArmedVec());
  endtask

  task automatic applyStimulus(input string tag, input int id, input logic cancel, input logic [63:0] dl);
    int waited = 0;
    arm_valid_i    = 1'b1;
    arm_id_i       = IdW'(id);
    arm_cancel_i   = cancel;
    arm_deadline_i = dl;
    while (!arm_ready_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput({tag, "_armReady"}, 64'(arm_ready_o), 64'd1);
    @(posedge clk_i);
    #1 arm_valid_i = 1'b0;
    modelArmed[id] = !cancel;
    if (!cancel) modelDl[id] = dl;
    waitScanDone(tag);
  endtask

  task automatic ackExpiry(input string tag);
    int waited = 0;
    int expId;
    while (!expired_valid_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    expId = modelNextId();
    checkOutput({tag, "_expValid"}, 64'(expired_valid_o), 64'd1);
    checkOutput({tag, "_expId"}, 64'(expired_id_o), 64'(expId));
    expired_ready_i = 1'b1;
    @(posedge clk_i);
    #1 expired_ready_i = 1'b0;
    if (expId >= 0) modelArmed[expId] = 1'b0;
    waitScanDone(tag);
  endtask

  initial begin
    int seen;
    int drains;
    rst_i = 1'b1; arm_valid_i = 1'b0; arm_id_i = '0; arm_cancel_i = 1'b0;
    arm_deadline_i = '0; mtime_i = '0; expired_ready_i = 1'b0;
    modelClear();

    repeat (2) @(negedge clk_i);
    checkOutput("rstArmReady", 64'(arm_ready_o), 64'd0);
    checkOutput("rstCmpValue", cmp_value_o, AllOnes);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idleArmReady", 64'(arm_ready_o), 64'd1);
    checkOutput("idleCmpValid", 64'(cmp_valid_o), 64'd0);
    checkOutput("idleCmpValue", cmp_value_o, AllOnes);
    checkOutput("idleExpValid", 64'(expired_valid_o), 64'd0);
    checkOutput("idleArmed", 64'(armed_o), 64'd0);

    // Basic arm/expire/rescan.
    applyStimulus("arm2", 2, 1'b0, 64'd100);
    applyStimulus("arm0", 0, 1'b0, 64'd300);
    checkOutput("basicCmp", cmp_value_o, 64'd100);
    mtime_i = 64'd100;
    ackExpiry("fire2");
    checkOutput("afterFire2Cmp", cmp_value_o, 64'd300);
    checkOutput("afterFire2Armed", 64'(armed_o), 64'b0001);
    applyStimulus("cancel0", 0, 1'b1, 64'd0);

    // Equal deadlines fire in ascending id order.
    mtime_i = 64'd0;
    applyStimulus("tieArm1", 1, 1'b0, 64'd50);
    applyStimulus("tieArm3", 3, 1'b0, 64'd50);
    mtime_i = 64'd60;
    ackExpiry("tieFirst");
    ackExpiry("tieSecond");
    checkOutput("tieDoneValid", 64'(cmp_valid_o), 64'd0);

    // Past deadline fires right after the scan and holds under backpressure.
    mtime_i = 64'd500;
    applyStimulus("past0", 0, 1'b0, 64'd10);
    @(negedge clk_i);
    checkOutput("pastFireValid", 64'(expired_valid_o), 64'd1);
    checkOutput("pastFireId", 64'(expired_id_o), 64'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      checkOutput("holdValid", 64'(expired_valid_o), 64'd1);
      checkOutput("holdId", 64'(expired_id_o), 64'd0);
      checkOutput("holdArmReady", 64'(arm_ready_o), 64'd0);
    end
    ackExpiry("pastAck");

    // Cancelled deadline never expires.
    mtime_i = 64'd0;
    applyStimulus("arm1k", 1, 1'b0, 64'd1000);
    applyStimulus("cancel1k", 1, 1'b1, 64'd0);
    seen = 0;
    for (int m = 0; m <= 2000; m += 100) begin
      mtime_i = 64'(m);
      @(negedge clk_i);
      if (expired_valid_o) seen++;
    end
    checkOutput("cancelNoExpiry", 64'(seen), 64'd0);

    // Randomized deadlines (ties likely), an overwrite and a random cancel, then drain.
    mtime_i = 64'd0;
    for (int i = 0; i < NumSlots; i++)
      applyStimulus("rndArm", i, 1'b0, 64'(1000 + 10 * $urandom_range(0, 5)));
    applyStimulus("rndOverwrite", int'($urandom_range(0, NumSlots - 1)), 1'b0,
                  64'(1000 + 10 * $urandom_range(0, 5)));
    applyStimulus("rndCancel", int'($urandom_range(0, NumSlots - 1)), 1'b1, 64'd0);
    drains = 0;
    for (int i = 0; i < NumSlots; i++) if (modelArmed[i]) drains++;
    mtime_i = 64'd5000;
    repeat (drains) ackExpiry("rndDrain");
    checkOutput("rndDoneValid", 64'(cmp_valid_o), 64'd0);

    // Reset in the middle of a scan.
    mtime_i = 64'd0;
    arm_valid_i = 1'b1; arm_id_i = 2'd2; arm_cancel_i = 1'b0; arm_deadline_i = 64'd77;
    @(posedge clk_i);
    #1 arm_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("scanRstArmed", 64'(armed_o), 64'd0);
    checkOutput("scanRstCmpValue", cmp_value_o, AllOnes);
    checkOutput("scanRstCmpValid", 64'(cmp_valid_o), 64'd0);
    checkOutput("scanRstArmReady", 64'(arm_ready_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    modelClear();
    @(negedge clk_i);
    checkOutput("scanRstUpdate", 64'(cmp_update_o), 64'd0);

    // Reset while an expiry is pending.
    mtime_i = 64'd10;
    applyStimulus("fireRstArm", 1, 1'b0, 64'd5);
    @(negedge clk_i);
    checkOutput("fireRstPending", 64'(expired_valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("fireRstExpValid", 64'(expired_valid_o), 64'd0);
    checkOutput("fireRstExpId", 64'(expired_id_o), 64'd0);
    checkOutput("fireRstArmed", 64'(armed_o), 64'd0);
    checkOutput("fireRstCmpValid", 64'(cmp_valid_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    modelClear();
    mtime_i = 64'd1000;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (expired_valid_o) seen++;
    end
    checkOutput("postRstNoExpiry", 64'(seen), 64'd0);
    checkOutput("postRstArmed", 64'(armed_o), 64'd0);
    checkOutput("postRstArmReady", 64'(arm_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv_timer_sched.md
Name: rv_timer_sched

Overview:
Multiplexes one 64-bit hardware timer compare channel between NumSlots software deadlines. Holds the deadlines and finds the earliest armed one with a sequential scan, one slot per cycle. Drives that deadline onto the timer compare register. When mtime reaches it, emits the expiring slot id on a ready/valid stream. Sits between the CSR/firmware-facing deadline interface and the rv_timer compare/interrupt logic.

Parameters:
NumSlots, 4, number of deadline slots (2..16)
TimerW, 64, width of mtime and deadlines
IdW, $clog2(NumSlots), slot id width (localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
arm_valid_i  in  1  arm/cancel request valid
arm_ready_o  out  1  request accepted when valid&ready
arm_id_i  in  IdW  target slot
arm_cancel_i  in  1  1 = disarm slot, 0 = arm with deadline
arm_deadline_i  in  TimerW  absolute deadline
mtime_i  in  TimerW  current timer value
cmp_value_o  out  TimerW  compare value for timer
cmp_valid_o  out  1  at least one slot armed
cmp_update_o  out  1  one-cycle pulse: cmp_value_o/cmp_valid_o just changed
expired_valid_o  out  1  expiry event valid
expired_id_o  out  IdW  expiring slot
expired_ready_i  in  1  consumer accepts expiry
armed_o  out  NumSlots  per-slot armed flags

Behaviour:
- Reset (async, rst_i=1): all slots disarmed, deadlines 0, state IDLE; cmp_value_o='1, cmp_valid_o=0, cmp_update_o=0, expired_valid_o=0, expired_id_o=0, armed_o=0, arm_ready_o=0 while rst_i high. Reset mid-scan or mid-fire aborts. No event is retained.
- FSM states: IDLE, SCAN, FIRE.
- IDLE: the block checks for expiry each cycle: hit = cmp_valid_o && (mtime_i >= cmp_value_o), an unsigned 64-bit compare.
  - If hit: arm_ready_o=0, next state FIRE.
  - Else: arm_ready_o=1. On handshake, the slot is updated at the end of the cycle and the next state is SCAN.
  - Arm on an armed slot overwrites its deadline. Cancel on a disarmed slot is legal; a rescan still occurs.
- SCAN: arm_ready_o=0.
  - Index i runs 0..NumSlots-1, one slot per cycle, keeping running min deadline and min id among armed slots.
  - Strict less-than, so ties resolve to the lowest id.
  - At the end of the last scan cycle, cmp_value_o <= min (or '1 if none armed) and cmp_valid_o <= any armed. Next state is IDLE.
  - cmp_update_o=1 in the first IDLE cycle after every scan, even if the value is unchanged.
- Latency: arm handshake in cycle T -> SCAN cycles T+1..T+NumSlots -> new cmp outputs and cmp_update_o in cycle T+NumSlots+1. Earliest FIRE is T+NumSlots+2.
- FIRE: expired_valid_o=1, expired_id_o=registered min id, arm_ready_o=0.
  - Holds stable until expired_ready_i. On handshake, the slot is disarmed and the next state is SCAN.
  - expired_valid_o must not drop or change without a handshake.
- Past deadlines (deadline <= mtime at arm time) fire right after the scan. There is no wrap-around handling: the 64-bit counter is treated as never wrapping.
- Equal deadlines in several slots fire one per FIRE/SCAN round, in ascending id order.
- mtime_i decreasing (timer rewritten) is legal. The compare is simply re-evaluated each IDLE cycle.
- armed_o reflects slot registers directly and updates the cycle after arm/cancel or expiry handshake.
- Out-of-range arm_id_i (>= NumSlots, non-power-of-two case) is accepted and ignored, but still triggers a rescan.

Decomposition:
- Package rv_timer_sched_pkg: state enum (IDLE, SCAN, FIRE); slot struct {armed, deadline[TimerW]}; constant TimerDisabled = '1.
- One natural sub-module, rv_timer_sched_slots: slot register file with write port (arm/cancel/expire-clear), read port by scan index, and armed vector. FSM and min-tracking stay in the top.

Test Plan:
- Reset then idle, NumSlots=4 -> cmp_valid_o=0, cmp_value_o=64'hFFFF_FFFF_FFFF_FFFF, expired_valid_o=0, arm_ready_o=1.
- Arm slot2=100, slot0=300 with mtime=0 -> after each arm, cmp_update_o pulses exactly 5 cycles post-handshake. Final cmp_value_o=100. Raise mtime to 100 -> expired_id_o=2. Ack -> rescan gives cmp_value_o=300, armed_o=4'b0001.
- Arm slot1=50 and slot3=50 -> expiry ids 1 then 3. After second ack, cmp_valid_o=0.
- Arm slot0=10 with mtime=500 -> FIRE with id 0 at cycle T+6. Hold expired_ready_i=0 for 20 cycles -> valid/id stay stable, arm_ready_o=0 throughout.
- Arm slot1=1000, then cancel slot1 before expiry, mtime sweeps past 1000 -> no expiry; cmp_valid_o=0 after cancel scan.
- Assert rst_i during SCAN and during FIRE -> all outputs return to reset values immediately. After release, no stale expiry and armed_o=0.
